load_store_unit: RTL and testbench

Multi-cycle load/store sequencer between the core's execute stage and the data memory. It accepts one byte, halfword or word access per valid/ready handshake. It converts the byte address to the memory's word address and performs read-modify-write for sub-word stores, since the memory only writes full words. Load data is lane-extracted, sign- or zero-extended, and returned on a response handshake.

---
 rtl/load_store_unit_if.sv | 36 +++
 rtl/load_store_unit.sv | 157 +++++++++++++++
 tb/tb_load_store_unit.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory bus of the load/store unit.
// master = execute stage + memory side, slave = load_store_unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] Adr;
  logic [31:0] MWD;
  logic        MWR;
  logic        MOE;
  logic [31:0] MRD;

  modport master (
    output req_valid, req_we, req_size,
    output req_signed, req_addr, req_wdata,
    output rsp_ready, MRD,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err, Adr, MWD, MWR, MOE
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_signed, req_addr, req_wdata,
    input  rsp_ready, MRD,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err, Adr, MWD, MWR, MOE
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store sequencer: byte/half/word access, RMW for sub-word
// stores. Ports: clk, rst (async high), bus (load_store_unit_if.slave).
// Optional macro LSU_ALIGN_CHECK_EN enables misalignment errors (rsp_err).
module load_store_unit (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_we_q;
  logic        r_signed_q;
  logic [1:0]  r_size_q;
  logic [31:0] r_addr_q;
  logic [31:0] r_wdata_q;
  logic [31:0] r_word_q;
  logic [31:0] r_rdata;

  logic        w_accept;
  logic        w_err;
  logic        w_ready;
  logic        w_valid;
  logic        w_moe;
  logic        w_mwr;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign w_accept = bus.req_valid && w_ready;

`ifdef LSU_ALIGN_CHECK_EN
  logic r_err;
  // size 11 is treated as a word access
  assign w_err = (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                 (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);
  assign bus.rsp_err = r_err;
`else
  assign w_err = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  // little-endian lane extraction from memory read data
  assign w_byte = bus.MRD[{r_addr_q[1:0], 3'b000} +: 8];
  assign w_half = bus.MRD[{r_addr_q[1], 4'b0000} +: 16];

  always_comb begin
    w_load = bus.MRD;
    unique case (1'b1)
      (r_size_q == 2'b00):
        w_load = {{24{r_signed_q & w_byte[7]}}, w_byte};
      (r_size_q == 2'b01):
        w_load = {{16{r_signed_q & w_half[15]}}, w_half};
      r_size_q[1]:
        w_load = bus.MRD;
    endcase
  end

  // merged word for the WRITE cycle
  always_comb begin
    w_merged = r_word_q;
    unique case (1'b1)
      (r_size_q == 2'b00):
        w_merged[{r_addr_q[1:0], 3'b000} +: 8] = r_wdata_q[7:0];
      (r_size_q == 2'b01):
        w_merged[{r_addr_q[1], 4'b0000} +: 16] = r_wdata_q[15:0];
      r_size_q[1]:
        w_merged = r_wdata_q;
    endcase
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_valid = 1'b0;
    w_moe   = 1'b0;
    w_mwr   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.req_valid) begin
          if (w_err)
            w_next = S_RESP;
          else if (bus.req_we && bus.req_size[1])
            w_next = S_WRITE;
          else
            w_next = S_READ;
        end
      end
      S_READ: begin
        w_moe  = 1'b1;
        w_next = r_we_q ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        w_mwr  = 1'b1;
        w_next = S_RESP;
      end
      S_RESP: begin
        w_valid = 1'b1;
        if (bus.rsp_ready)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_we_q     <= 1'b0;
      r_signed_q <= 1'b0;
      r_size_q   <= 2'b00;
      r_addr_q   <= '0;
      r_wdata_q  <= '0;
      r_word_q   <= '0;
      r_rdata    <= '0;
`ifdef LSU_ALIGN_CHECK_EN
      r_err      <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we_q     <= bus.req_we;
        r_signed_q <= bus.req_signed;
        r_size_q   <= bus.req_size;
        r_addr_q   <= bus.req_addr;
        r_wdata_q  <= bus.req_wdata;
        r_rdata    <= '0;
`ifdef LSU_ALIGN_CHECK_EN
        r_err      <= w_err;
`endif
      end
      if (r_state == S_READ) begin
        r_word_q <= bus.MRD;
        if (!r_we_q)
          r_rdata <= w_load;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = w_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.MOE       = w_moe;
  assign bus.MWR       = w_mwr;
  assign bus.Adr       = {2'b00, r_addr_q[31:2]};
  assign bus.MWD       = w_merged;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 16-word memory model.
// Build with +define+LSU_ALIGN_CHECK_EN to exercise alignment errors.
module tb_load_store_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [31:0] mem [0:15];
  logic        pre_en;
  logic [3:0]  pre_a;
  logic [31:0] pre_d;
  int          wr_cnt;
  int          rd_cnt;
  logic [31:0] last_wr_adr;
  logic [31:0] last_wr_data;

  load_store_unit_if u_if ();

  load_store_unit u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign u_if.MRD = mem[u_if.Adr[3:0]];

  always @(posedge clk) begin
    if (pre_en)
      mem[pre_a] <= pre_d;
    else if (u_if.MWR) begin
      mem[u_if.Adr[3:0]] <= u_if.MWD;
      last_wr_adr  <= u_if.Adr;
      last_wr_data <= u_if.MWD;
      wr_cnt       <= wr_cnt + 1;
    end
    if (u_if.MOE)
      rd_cnt <= rd_cnt + 1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if ((u_if.MOE && u_if.MWR) !== 1'b0) begin
        n_fail++;
        $display("FAIL moe_mwr_excl: MOE=%b MWR=%b required not both 1",
                 u_if.MOE, u_if.MWR);
      end
    end
  end

  task automatic preload(input logic [3:0] a, input logic [31:0] d);
    pre_en = 1'b1;
    pre_a  = a;
    pre_d  = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // issues one request, returns cycles until rsp_valid seen (accept edge = 0)
  task automatic do_req(input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat,
                        output logic [31:0] rd, output logic er);
    int guard;
    guard = 0;
    while (!u_if.req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    u_if.req_valid  = 1'b1;
    u_if.req_we     = we;
    u_if.req_size   = sz;
    u_if.req_signed = sg;
    u_if.req_addr   = addr;
    u_if.req_wdata  = wd;
    @(posedge clk); #1;
    u_if.req_valid = 1'b0;
    lat = 1;
    while (!u_if.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = u_if.rsp_rdata;
    er = u_if.rsp_err;
  endtask

  task automatic finish_rsp;
    u_if.rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, u_if.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, u_if.rsp_valid}, 32'd0);
    check("rst_rsp_rdata", u_if.rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, u_if.rsp_err}, 32'd0);
    check("rst_moe", {31'd0, u_if.MOE}, 32'd0);
    check("rst_mwr", {31'd0, u_if.MWR}, 32'd0);
    check("rst_adr", u_if.Adr, 32'd0);
    check("rst_mwd", u_if.MWD, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word;
    int lat;
    logic [31:0] rd;
    logic er;
    int w0;
    w0 = wr_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er);
    check("wst_lat", lat, 32'd2);
    check("wst_rdata", rd, 32'd0);
    check("wst_err", {31'd0, er}, 32'd0);
    finish_rsp();
    check("wst_wr_cnt", wr_cnt - w0, 32'd1);
    check("wst_adr", last_wr_adr, 32'd4);
    check("wst_mem", mem[4], 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, lat, rd, er);
    check("wld_lat", lat, 32'd2);
    check("wld_rdata", rd, 32'hDEADBEEF);
    check("wld_err", {31'd0, er}, 32'd0);
    finish_rsp();
  endtask

  task automatic test_byte_store;
    int lat;
    logic [31:0] rd;
    logic er;
    int r0;
    preload(4'd4, 32'h11223344);
    r0 = rd_cnt;
    do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA, lat, rd, er);
    check("bst_lat", lat, 32'd3);
    check("bst_rdata", rd, 32'd0);
    check("bst_rd_cycles", rd_cnt - r0, 32'd1);
    check("bst_mwd", last_wr_data, 32'h11AA3344);
    check("bst_mem", mem[4], 32'h11AA3344);
    finish_rsp();
  endtask

  task automatic test_load_ext;
    int lat;
    logic [31:0] rd;
    logic er;
    preload(4'd4, 32'h80FF7F01);
    do_req(1'b0, 2'b00, 1'b1, 32'h12, 32'd0, lat, rd, er);
    check("lb_s_12", rd, 32'hFFFFFFFF);
    check("lb_lat", lat, 32'd2);
    finish_rsp();
    do_req(1'b0, 2'b00, 1'b0, 32'h12, 32'd0, lat, rd, er);
    check("lb_u_12", rd, 32'h000000FF);
    finish_rsp();
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'd0, lat, rd, er);
    check("lh_s_12", rd, 32'hFFFF80FF);
    finish_rsp();
    do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'd0, lat, rd, er);
    check("lh_u_10", rd, 32'h00007F01);
    finish_rsp();
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'd0, lat, rd, er);
    check("lb_s_11", rd, 32'h0000007F);
    finish_rsp();
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, lat, rd, er);
    check("lb_u_13", rd, 32'h00000080);
    finish_rsp();
  endtask

  task automatic test_backpressure;
    int lat;
    logic [31:0] rd;
    logic er;
    int r0;
    u_if.rsp_ready = 1'b0;
    do_req(1'b0, 2'b00, 1'b1, 32'h12, 32'd0, lat, rd, er);
    check("bp_lat", lat, 32'd2);
    r0 = rd_cnt;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", {31'd0, u_if.rsp_valid}, 32'd1);
      check("bp_rdata", u_if.rsp_rdata, 32'hFFFFFFFF);
      check("bp_req_ready", {31'd0, u_if.req_ready}, 32'd0);
    end
    check("bp_no_moe", rd_cnt - r0, 32'd0);
    finish_rsp();
    check("bp_rel_valid", {31'd0, u_if.rsp_valid}, 32'd0);
    check("bp_rel_ready", {31'd0, u_if.req_ready}, 32'd1);
  endtask

  task automatic test_misaligned;
    int lat;
    logic [31:0] rd;
    logic er;
    int r0;
    int w0;
    r0 = rd_cnt;
    w0 = wr_cnt;
    do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'd0, lat, rd, er);
`ifdef LSU_ALIGN_CHECK_EN
    check("mis_w_lat", lat, 32'd1);
    check("mis_w_err", {31'd0, er}, 32'd1);
    check("mis_w_rdata", rd, 32'd0);
    check("mis_w_no_moe", rd_cnt - r0, 32'd0);
`else
    check("mis_w_lat", lat, 32'd2);
    check("mis_w_err", {31'd0, er}, 32'd0);
    check("mis_w_rdata", rd, 32'h80FF7F01);
`endif
    finish_rsp();
    do_req(1'b0, 2'b01, 1'b0, 32'h11, 32'd0, lat, rd, er);
`ifdef LSU_ALIGN_CHECK_EN
    check("mis_h_err", {31'd0, er}, 32'd1);
    check("mis_h_rdata", rd, 32'd0);
    check("mis_h_no_moe", rd_cnt - r0, 32'd0);
`else
    check("mis_h_err", {31'd0, er}, 32'd0);
    check("mis_h_rdata", rd, 32'h00007F01);
`endif
    finish_rsp();
    check("mis_no_mwr", wr_cnt - w0, 32'd0);
  endtask

  task automatic test_reset_mid;
    int w0;
    int lat;
    logic [31:0] rd;
    logic er;
    preload(4'd5, 32'h55667788);
    w0 = wr_cnt;
    u_if.req_valid  = 1'b1;
    u_if.req_we     = 1'b1;
    u_if.req_size   = 2'b01;
    u_if.req_signed = 1'b0;
    u_if.req_addr   = 32'h14;
    u_if.req_wdata  = 32'h0000BEEF;
    @(posedge clk); #1;
    u_if.req_valid = 1'b0;
    check("mid_moe_read", {31'd0, u_if.MOE}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_moe_rst", {31'd0, u_if.MOE}, 32'd0);
    check("mid_ready_rst", {31'd0, u_if.req_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_ready_rel", {31'd0, u_if.req_ready}, 32'd1);
    check("mid_no_write", wr_cnt - w0, 32'd0);
    check("mid_mem", mem[5], 32'h55667788);
    do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h1234BEEF, lat, rd, er);
    check("hst_lat", lat, 32'd3);
    finish_rsp();
    check("hst_mem", mem[5], 32'hBEEF7788);
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    wr_cnt          = 0;
    rd_cnt          = 0;
    last_wr_adr     = '0;
    last_wr_data    = '0;
    pre_en          = 1'b0;
    pre_a           = '0;
    pre_d           = '0;
    u_if.req_valid  = 1'b0;
    u_if.req_we     = 1'b0;
    u_if.req_size   = 2'b00;
    u_if.req_signed = 1'b0;
    u_if.req_addr   = '0;
    u_if.req_wdata  = '0;
    u_if.rsp_ready  = 1'b1;
    test_reset();
    test_word();
    test_byte_store();
    test_load_ext();
    test_backpressure();
    test_misaligned();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
